// File: rtl/raster_sequencer.sv
// rtl/raster_sequencer.sv - triangle fetch, cull and bounding-box pixel sequencer
//
// Reads triangles from vertex memory, recentres them to screen space and clips
// the bounding box. Off-screen, degenerate and (optionally) back-facing
// triangles are culled. Each surviving box is streamed one pixel per
// handshake. An optional clear pass over the whole screen comes first.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start                  one-cycle run request, honoured only when idle
//   i_vertex_count           memory words in the triangle list
//   i_clear_en/i_clear_color clear pass enable and colour
//   o_mem_addr/i_mem_data    vertex memory port, one-cycle read latency
//   o_pix_*/i_pix_ready      pixel stream (valid/ready) with colour and clear flag
//   o_v{1,2,3}_{x,y}         current recentred triangle
//   o_bb_width/o_bb_height   BR - TL of the current box
//   o_busy, o_done           activity flag and end-of-run pulse
//   o_tri_drawn/o_tri_culled saturating per-run triangle counters
module raster_sequencer #(
  parameter int COORD_W       = 11,
  parameter int ADDR_W        = 14,
  parameter int SCREEN_W      = 800,
  parameter int SCREEN_H      = 600,
  parameter int ORIGIN_X      = 400,
  parameter int ORIGIN_Y      = 300,
  parameter int VERTEX_STRIDE = 4,
  parameter int CULL_BACKFACE = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [31:0]        i_vertex_count,
  input  logic               i_clear_en,
  input  logic [7:0]         i_clear_color,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [COORD_W-1:0] i_mem_data,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [COORD_W-1:0] o_pix_x,
  output logic [COORD_W-1:0] o_pix_y,
  output logic [7:0]         o_pix_color,
  output logic               o_pix_clear,
  output logic [COORD_W-1:0] o_v1_x,
  output logic [COORD_W-1:0] o_v1_y,
  output logic [COORD_W-1:0] o_v2_x,
  output logic [COORD_W-1:0] o_v2_y,
  output logic [COORD_W-1:0] o_v3_x,
  output logic [COORD_W-1:0] o_v3_y,
  output logic [COORD_W-1:0] o_bb_width,
  output logic [COORD_W-1:0] o_bb_height,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        o_tri_drawn,
  output logic [15:0]        o_tri_culled
);

  localparam int WORDS   = 3 * VERTEX_STRIDE;
  localparam int FCNT_W  = $clog2(WORDS + 1);
  localparam int WORD_W  = $clog2(VERTEX_STRIDE);
  localparam int CROSS_W = 2 * COORD_W + 2;
  localparam logic signed [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] OX = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] OY = COORD_W'(ORIGIN_Y);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_MINMAX, S_CLIP, S_CHECK, S_SCAN, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [31:0]               r_tri_left;
  logic [7:0]                r_color;
  logic [7:0]                r_clear_color;
  logic [FCNT_W-1:0]         r_fcnt;
  logic [WORD_W-1:0]         r_word;
  logic [1:0]                r_vert;
  logic                      r_cap_valid;
  logic [WORD_W-1:0]         r_cap_word;
  logic [1:0]                r_cap_vert;
  logic signed [COORD_W-1:0] r_v1_x, r_v1_y, r_v2_x, r_v2_y, r_v3_x, r_v3_y;
  logic signed [COORD_W-1:0] r_tl_x, r_tl_y, r_br_x, r_br_y;
  logic signed [COORD_W-1:0] r_pix_x, r_pix_y;
  logic [7:0]                r_pix_color;
  logic                      r_pix_clear;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic [15:0]               r_tri_drawn, r_tri_culled;

  function automatic logic signed [COORD_W-1:0] min3(
    input logic signed [COORD_W-1:0] a, input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    m = (c < m) ? c : m;
    return m;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(
    input logic signed [COORD_W-1:0] a, input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return m;
  endfunction

  logic [31:0] w_start_tris;
  logic        w_issue;
  logic        w_more;
  logic        w_clip_cull;
  logic        w_check_cull;
  logic        w_fire;
  logic        w_x_end;
  logic        w_last;
  logic signed [CROSS_W-1:0] w_e1x, w_e1y, w_e2x, w_e2y, w_cross;

  assign w_start_tris = i_vertex_count / 32'(WORDS);
  assign w_issue      = (r_fcnt < FCNT_W'(WORDS));
  // tri_left still holds the current triangle, so "more" means at least two
  assign w_more       = (r_tri_left > 32'd1);

  assign w_clip_cull = r_br_x[COORD_W-1] | r_br_y[COORD_W-1] |
                       (r_tl_x > XMAX) | (r_tl_y > YMAX);

  // Edge vectors are widened before subtraction so the cross product cannot overflow
  assign w_e1x   = CROSS_W'(r_v2_x) - CROSS_W'(r_v1_x);
  assign w_e1y   = CROSS_W'(r_v2_y) - CROSS_W'(r_v1_y);
  assign w_e2x   = CROSS_W'(r_v3_x) - CROSS_W'(r_v1_x);
  assign w_e2y   = CROSS_W'(r_v3_y) - CROSS_W'(r_v1_y);
  assign w_cross = (w_e1x * w_e2y) - (w_e1y * w_e2x);

  assign w_check_cull = (r_tl_x == r_br_x) | (r_tl_y == r_br_y) |
                        ((CULL_BACKFACE != 0) &&
                         (w_cross[CROSS_W-1] || (w_cross == '0)));

  assign w_fire  = (r_state == S_SCAN) && i_pix_ready;
  assign w_x_end = (r_pix_x == r_br_x);
  assign w_last  = w_x_end && (r_pix_y == r_br_y);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_pix_valid = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_clear_en)              w_next = S_CLEAR;
          else if (w_start_tris == '0) w_next = S_DONE;
          else                         w_next = S_FETCH;
        end
      end
      S_CLEAR:  w_next = S_SCAN;
      S_FETCH:  if (!w_issue) w_next = S_MINMAX;
      S_MINMAX: w_next = S_CLIP;
      S_CLIP: begin
        if (w_clip_cull) w_next = w_more ? S_FETCH : S_DONE;
        else             w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_check_cull) w_next = w_more ? S_FETCH : S_DONE;
        else              w_next = S_SCAN;
      end
      S_SCAN: begin
        o_pix_valid = 1'b1;
        if (w_fire && w_last) begin
          // the clear pass does not consume a triangle
          if (r_pix_clear) w_next = (r_tri_left != '0) ? S_FETCH : S_DONE;
          else             w_next = w_more ? S_FETCH : S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tri_left    <= '0;
      r_color       <= 8'd1;
      r_clear_color <= '0;
      r_fcnt        <= '0;
      r_word        <= '0;
      r_vert        <= '0;
      r_cap_valid   <= 1'b0;
      r_cap_word    <= '0;
      r_cap_vert    <= '0;
      r_v1_x <= '0; r_v1_y <= '0; r_v2_x <= '0;
      r_v2_y <= '0; r_v3_x <= '0; r_v3_y <= '0;
      r_tl_x <= '0; r_tl_y <= '0; r_br_x <= '0; r_br_y <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_color   <= '0;
      r_pix_clear   <= 1'b0;
      r_mem_addr    <= '0;
      r_tri_drawn   <= '0;
      r_tri_culled  <= '0;
    end else begin
      // Memory answers one cycle after the address, so the word/vertex tag is delayed too
      r_cap_valid <= (r_state == S_FETCH) && w_issue;
      r_cap_word  <= r_word;
      r_cap_vert  <= r_vert;

      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mem_addr    <= '0;
            r_tri_left    <= w_start_tris;
            r_color       <= 8'd1;
            r_clear_color <= i_clear_color;
            r_tri_drawn   <= '0;
            r_tri_culled  <= '0;
            r_fcnt        <= '0;
            r_word        <= '0;
            r_vert        <= '0;
          end
        end
        S_CLEAR: begin
          r_tl_x      <= '0;
          r_tl_y      <= '0;
          r_br_x      <= XMAX;
          r_br_y      <= YMAX;
          r_pix_x     <= '0;
          r_pix_y     <= '0;
          r_pix_clear <= 1'b1;
          r_pix_color <= r_clear_color;
        end
        S_FETCH: begin
          if (w_issue) begin
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
            r_fcnt     <= r_fcnt + FCNT_W'(1);
            if (r_word == WORD_W'(VERTEX_STRIDE - 1)) begin
              r_word <= '0;
              r_vert <= r_vert + 2'd1;
            end else begin
              r_word <= r_word + WORD_W'(1);
            end
          end else begin
            // counters rearmed here so every FETCH entry starts from zero
            r_fcnt <= '0;
            r_word <= '0;
            r_vert <= '0;
          end
          if (r_cap_valid) begin
            if (r_cap_word == WORD_W'(0)) begin
              unique case (r_cap_vert)
                2'd0:    r_v1_x <= i_mem_data + OX;
                2'd1:    r_v2_x <= i_mem_data + OX;
                default: r_v3_x <= i_mem_data + OX;
              endcase
            end else if (r_cap_word == WORD_W'(1)) begin
              unique case (r_cap_vert)
                2'd0:    r_v1_y <= i_mem_data + OY;
                2'd1:    r_v2_y <= i_mem_data + OY;
                default: r_v3_y <= i_mem_data + OY;
              endcase
            end
          end
        end
        S_MINMAX: begin
          r_tl_x <= min3(r_v1_x, r_v2_x, r_v3_x);
          r_tl_y <= min3(r_v1_y, r_v2_y, r_v3_y);
          r_br_x <= max3(r_v1_x, r_v2_x, r_v3_x);
          r_br_y <= max3(r_v1_y, r_v2_y, r_v3_y);
        end
        S_CLIP: begin
          if (w_clip_cull) begin
            r_tri_culled <= (r_tri_culled == 16'hFFFF) ? r_tri_culled : r_tri_culled + 16'd1;
            r_tri_left   <= r_tri_left - 32'd1;
          end else begin
            r_tl_x <= r_tl_x[COORD_W-1] ? '0 : r_tl_x;
            r_tl_y <= r_tl_y[COORD_W-1] ? '0 : r_tl_y;
            r_br_x <= (r_br_x > XMAX) ? XMAX : r_br_x;
            r_br_y <= (r_br_y > YMAX) ? YMAX : r_br_y;
          end
        end
        S_CHECK: begin
          if (w_check_cull) begin
            r_tri_culled <= (r_tri_culled == 16'hFFFF) ? r_tri_culled : r_tri_culled + 16'd1;
            r_tri_left   <= r_tri_left - 32'd1;
          end else begin
            r_pix_x     <= r_tl_x;
            r_pix_y     <= r_tl_y;
            r_pix_clear <= 1'b0;
            r_pix_color <= r_color;
          end
        end
        S_SCAN: begin
          if (w_fire) begin
            if (w_last) begin
              if (r_pix_clear) begin
                r_pix_clear <= 1'b0;
              end else begin
                r_tri_drawn <= (r_tri_drawn == 16'hFFFF) ? r_tri_drawn : r_tri_drawn + 16'd1;
                r_color     <= r_color + 8'd1;
                r_tri_left  <= r_tri_left - 32'd1;
              end
            end else if (w_x_end) begin
              r_pix_x <= r_tl_x;
              r_pix_y <= r_pix_y + COORD_W'(1);
            end else begin
              r_pix_x <= r_pix_x + COORD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_pix_x      = r_pix_x;
  assign o_pix_y      = r_pix_y;
  assign o_pix_color  = r_pix_color;
  assign o_pix_clear  = r_pix_clear;
  assign o_v1_x       = r_v1_x;
  assign o_v1_y       = r_v1_y;
  assign o_v2_x       = r_v2_x;
  assign o_v2_y       = r_v2_y;
  assign o_v3_x       = r_v3_x;
  assign o_v3_y       = r_v3_y;
  assign o_bb_width   = r_br_x - r_tl_x;
  assign o_bb_height  = r_br_y - r_tl_y;
  assign o_tri_drawn  = r_tri_drawn;
  assign o_tri_culled = r_tri_culled;

endmodule

// File: tb/tb_raster_sequencer.sv
// tb/tb_raster_sequencer.sv - randomized model-checked bench for raster_sequencer
module tb_raster_sequencer;
  localparam int CW = 11, AW = 14, SW = 48, SH = 32, OX = 24, OY = 16, VS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   vcount = '0;
  logic          clear_en = 1'b0;
  logic [7:0]    clear_color = '0;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [CW-1:0] pix_x, pix_y;
  logic [7:0]    pix_color;
  logic          pix_clear;
  logic [CW-1:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
  logic [CW-1:0] bb_width, bb_height;
  logic          busy, done;
  logic [15:0]   tri_drawn, tri_culled;

  raster_sequencer #(
    .COORD_W(CW), .ADDR_W(AW), .SCREEN_W(SW), .SCREEN_H(SH),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .VERTEX_STRIDE(VS), .CULL_BACKFACE(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_vertex_count(vcount),
    .i_clear_en(clear_en), .i_clear_color(clear_color),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready),
    .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_color(pix_color), .o_pix_clear(pix_clear),
    .o_v1_x(v1_x), .o_v1_y(v1_y), .o_v2_x(v2_x), .o_v2_y(v2_y),
    .o_v3_x(v3_x), .o_v3_y(v3_y),
    .o_bb_width(bb_width), .o_bb_height(bb_height),
    .o_busy(busy), .o_done(done),
    .o_tri_drawn(tri_drawn), .o_tri_culled(tri_culled)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] mem [0:1023];
  always @(posedge clk) mem_data <= mem[mem_addr[9:0]];

  typedef struct {
    int x; int y; int color; bit clr;
    int v1x; int v1y; int v2x; int v2y; int v3x; int v3y; int bw; int bh;
  } pix_t;

  pix_t exp_q[$];
  int   exp_drawn, exp_culled;
  int   n_vec = 0, n_err = 0, pix_idx = 0;
  int   ready_pct = 100;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int sx(input logic [CW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrapc(input int v);
    logic [CW-1:0] t;
    t = v[CW-1:0];
    return sx(t);
  endfunction

  task automatic set_tri(input int t, input int x1, input int y1, input int x2,
                         input int y2, input int x3, input int y3);
    int b;
    b = t * 3 * VS;
    for (int w = 0; w < 3 * VS; w++) mem[b + w] = CW'($urandom);
    mem[b]          = CW'(x1); mem[b + 1]      = CW'(y1);
    mem[b + VS]     = CW'(x2); mem[b + VS + 1] = CW'(y2);
    mem[b + 2 * VS] = CW'(x3); mem[b + 2 * VS + 1] = CW'(y3);
  endtask

  // Expected pixel list straight from the rules: recentre, box, clip, cull, raster order
  task automatic build_model(input int vc, input bit ce, input int cc);
    pix_t p;
    int xs[3], ys[3];
    int minx, maxx, miny, maxy, area, b;
    exp_q.delete();
    exp_drawn = 0;
    exp_culled = 0;
    if (ce) begin
      for (int y = 0; y < SH; y++)
        for (int x = 0; x < SW; x++) begin
          p = '{x: x, y: y, color: cc, clr: 1'b1, default: 0};
          exp_q.push_back(p);
        end
    end
    for (int t = 0; t < vc / (3 * VS); t++) begin
      b = t * 3 * VS;
      for (int i = 0; i < 3; i++) begin
        xs[i] = wrapc(sx(mem[b + i * VS]) + OX);
        ys[i] = wrapc(sx(mem[b + i * VS + 1]) + OY);
      end
      minx = xs[0]; maxx = xs[0]; miny = ys[0]; maxy = ys[0];
      for (int i = 1; i < 3; i++) begin
        if (xs[i] < minx) minx = xs[i];
        if (xs[i] > maxx) maxx = xs[i];
        if (ys[i] < miny) miny = ys[i];
        if (ys[i] > maxy) maxy = ys[i];
      end
      if (maxx < 0 || maxy < 0 || minx > SW - 1 || miny > SH - 1) begin
        exp_culled++;
        continue;
      end
      if (minx < 0) minx = 0;
      if (miny < 0) miny = 0;
      if (maxx > SW - 1) maxx = SW - 1;
      if (maxy > SH - 1) maxy = SH - 1;
      area = (xs[1] - xs[0]) * (ys[2] - ys[0]) - (ys[1] - ys[0]) * (xs[2] - xs[0]);
      if (minx == maxx || miny == maxy || area <= 0) begin
        exp_culled++;
        continue;
      end
      for (int y = miny; y <= maxy; y++)
        for (int x = minx; x <= maxx; x++) begin
          p = '{x: x, y: y, color: (1 + exp_drawn) % 256, clr: 1'b0,
                v1x: xs[0], v1y: ys[0], v2x: xs[1], v2y: ys[1], v3x: xs[2], v3y: ys[2],
                bw: maxx - minx, bh: maxy - miny};
          exp_q.push_back(p);
        end
      exp_drawn++;
    end
  endtask

  pix_t          cp;
  bit            hold_prev = 1'b0;
  logic [CW-1:0] hx, hy;
  logic [7:0]    hc;
  logic          hclr;
  bit            bad;

  // One compare process: ready is chosen here, so the pixel seen now is the one
  // the DUT will accept at the coming rising edge.
  always @(negedge clk) begin
    pix_ready = ($urandom_range(0, 99) < ready_pct);
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (pix_valid && !busy) begin
        n_vec++; n_err++;
        $display("FAIL valid_when_idle: pix_valid=1 busy=0");
      end
      if (hold_prev) begin
        n_vec++;
        if (!pix_valid || pix_x != hx || pix_y != hy || pix_color != hc || pix_clear != hclr) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b x=%0d y=%0d c=%0h clr=%0b want v=1 x=%0d y=%0d c=%0h clr=%0b",
                   pix_valid, pix_x, pix_y, pix_color, pix_clear, hx, hy, hc, hclr);
        end
      end
      if (pix_valid && pix_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_pixel: got x=%0d y=%0d want no pixel", pix_x, pix_y);
        end else begin
          cp = exp_q.pop_front();
          bad = (int'(pix_x) != cp.x) || (int'(pix_y) != cp.y) ||
                (int'(pix_color) != cp.color) || (pix_clear != cp.clr);
          if (!cp.clr)
            bad = bad || sx(v1_x) != cp.v1x || sx(v1_y) != cp.v1y || sx(v2_x) != cp.v2x ||
                  sx(v2_y) != cp.v2y || sx(v3_x) != cp.v3x || sx(v3_y) != cp.v3y ||
                  int'(bb_width) != cp.bw || int'(bb_height) != cp.bh;
          if (bad) begin
            n_err++;
            $display("FAIL pixel %0d: got x=%0d y=%0d c=%0h clr=%0b bb=%0dx%0d want x=%0d y=%0d c=%0h clr=%0b bb=%0dx%0d",
                     pix_idx, pix_x, pix_y, pix_color, pix_clear, bb_width, bb_height,
                     cp.x, cp.y, cp.color, cp.clr, cp.bw, cp.bh);
          end
        end
        pix_idx++;
      end
      hold_prev = pix_valid && !pix_ready;
      hx = pix_x; hy = pix_y; hc = pix_color; hclr = pix_clear;
    end
  end

  task automatic run_job(input int vc, input bit ce, input int cc, input int pct,
                         input bit poke, output int lat);
    int cyc;
    bit seen;
    build_model(vc, ce, cc);
    ready_pct = pct;
    @(negedge clk);
    vcount = vc; clear_en = ce; clear_color = cc[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    lat = -1; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 30000) begin
      if (lat < 0 && pix_valid) lat = cyc;
      if (done) seen = 1'b1;
      start = (poke && cyc == 40);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("pixels_left", exp_q.size(), 0);
    check("tri_drawn", int'(tri_drawn), exp_drawn);
    check("tri_culled", int'(tri_culled), exp_culled);
  endtask

  int lat, n0, cyc, ntri, a, b, d, vc, pcts[3];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    pcts[0] = 100; pcts[1] = 30; pcts[2] = 70;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_pix_clear", int'(pix_clear), 0);
    check("rst_drawn", int'(tri_drawn), 0);
    check("rst_bb_width", int'(bb_width), 0);
    check("rst_v1_x", int'(v1_x), 0);
    rst = 1'b0;

    // basic right triangle, full rate, with a start poke that must be ignored
    set_tri(0, 0, 0, 10, 0, 0, 10);
    build_model(12, 1'b0, 0);
    check("model_t1_count", exp_q.size(), 121);
    check("model_t1_first_x", exp_q[0].x, 24);
    check("model_t1_first_y", exp_q[0].y, 16);
    check("model_t1_last_x", exp_q[120].x, 34);
    check("model_t1_color", exp_q[0].color, 1);
    run_job(12, 1'b0, 0, 100, 1'b1, lat);
    check("t1_latency", lat, 16);
    check("t1_drawn_lit", int'(tri_drawn), 1);
    check("t1_bb_width", int'(bb_width), 10);
    check("t1_bb_height", int'(bb_height), 10);

    // clear pass only
    build_model(0, 1'b1, 8'h55);
    check("model_clear_count", exp_q.size(), SW * SH);
    run_job(0, 1'b1, 8'h55, 100, 1'b0, lat);

    // off-screen cull then a clamped triangle
    set_tri(0, -100, 0, -80, 0, -100, 10);
    set_tri(1, -30, -20, 0, 0, -30, 0);
    build_model(24, 1'b0, 0);
    check("model_clamp_culled", exp_culled, 1);
    check("model_clamp_count", exp_q.size(), 25 * 17);
    run_job(24, 1'b0, 0, 100, 1'b0, lat);
    check("clamp_culled_lit", int'(tri_culled), 1);
    check("clamp_bb_width", int'(bb_width), 24);
    check("clamp_bb_height", int'(bb_height), 16);

    // winding and collinear culling
    set_tri(0, 0, 0, 10, 0, 0, 10);
    set_tri(1, 0, 0, 0, 10, 10, 0);
    set_tri(2, 0, 0, 5, 5, 10, 10);
    run_job(36, 1'b0, 0, 100, 1'b0, lat);
    check("winding_drawn_lit", int'(tri_drawn), 1);
    check("winding_culled_lit", int'(tri_culled), 2);

    // stalled stream with clear pass in front
    run_job(12 + 5, 1'b1, 8'hA3, 30, 1'b1, lat);

    // randomized triangle lists
    for (int j = 0; j < 8; j++) begin
      ready_pct = pcts[$urandom_range(0, 2)];
      ntri = (ready_pct == 30) ? $urandom_range(1, 2) : $urandom_range(1, 4);
      for (int t = 0; t < ntri; t++) begin
        if ($urandom_range(0, 5) == 0) begin
          a = $urandom_range(0, 20) - 10; b = $urandom_range(0, 14) - 7;
          d = $urandom_range(1, 5);
          set_tri(t, a, b, a + d, b + d, a + 2 * d, b + 2 * d);
        end else begin
          set_tri(t, $urandom_range(0, 40) - 20, $urandom_range(0, 28) - 14,
                  $urandom_range(0, 40) - 20, $urandom_range(0, 28) - 14,
                  $urandom_range(0, 40) - 20, $urandom_range(0, 28) - 14);
        end
      end
      vc = ntri * 3 * VS + $urandom_range(0, 3 * VS - 1);
      run_job(vc, ($urandom_range(0, 4) == 0), $urandom_range(0, 255), ready_pct, 1'b0, lat);
    end

    // reset in the middle of a scan, reset beating start, then a fresh run from address 0
    set_tri(0, 0, 0, 10, 0, 0, 10);
    set_tri(1, -10, -10, 10, -10, -10, 10);
    build_model(24, 1'b0, 0);
    n0 = exp_q.size();
    ready_pct = 100;
    @(negedge clk);
    vcount = 24; clear_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > n0 - 30 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reset_scan_reached", int'(cyc < 500), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", int'(pix_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_mem_addr", int'(mem_addr), 0);
    check("reset_drawn", int'(tri_drawn), 0);
    check("reset_pix_x", int'(pix_x), 0);
    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    check("reset_beats_start", int'(busy), 0);
    start = 1'b0;
    rst = 1'b0;
    run_job(12, 1'b0, 0, 100, 1'b0, lat);
    check("fresh_latency", lat, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
